// File: rtl/pwm_capture.sv
// PWM capture: measures high time, period and recovered duty of an incoming PWM line,
// flags off-nominal periods and stuck lines. Optional glitch filter: define PWM_DEGLITCH_EN.
module pwm_capture #(
  parameter int CW           = 16,
  parameter int NOM_PERIOD   = 256,
  parameter int TIMEOUT      = 1024,
  parameter int DEGLITCH_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic          meas_valid,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] period,
  output logic [7:0]    duty,
  output logic          period_err,
  output logic          stuck
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] NOM     = CW'(NOM_PERIOD);
  localparam logic [CW-1:0] TO      = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DUTY_MX = CW'(255);

  if (TIMEOUT < 2 || TIMEOUT >= (2 ** CW) - 1) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT out of range");
  end
  if (DEGLITCH_LEN < 1) begin : g_bad_deglitch
    $error("pwm_capture: DEGLITCH_LEN must be >= 1");
  end

  state_t        state;
  logic          s1, s2, s3, lvl;
  logic          rise, fall, edge_seen;
  logic [CW-1:0] hcnt, pcnt, ecnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= lvl;
    end
  end

`ifdef PWM_DEGLITCH_EN
  localparam int DW = $clog2(DEGLITCH_LEN + 1);
  logic [DW-1:0] dg_cnt;
  logic          filt;

  // Level moves only after s2 has disagreed with it for DEGLITCH_LEN straight samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      dg_cnt <= '0;
      filt   <= 1'b0;
    end else if (s2 == filt) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DW'(DEGLITCH_LEN - 1)) begin
      dg_cnt <= '0;
      filt   <= s2;
    end else begin
      dg_cnt <= dg_cnt + DW'(1);
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign rise      = lvl & ~s3;
  assign fall      = ~lvl & s3;
  assign edge_seen = rise | fall;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CNT_MAX) ? x : x + ONE;
  endfunction

  // Generator high time is code+1, so the recovered code is one less than the high count.
  function automatic logic [7:0] duty_of(input logic [CW-1:0] h);
    logic [CW-1:0] hm1;
    hm1 = h - ONE;
    if (h == '0)          return 8'h00;
    else if (hm1 > DUTY_MX) return 8'hFF;
    else                  return hm1[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      pcnt       <= '0;
      ecnt       <= '0;
      meas_valid <= 1'b0;
      high_time  <= '0;
      period     <= '0;
      duty       <= 8'h00;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (edge_seen)       ecnt <= '0;
      else if (ecnt != TO) ecnt <= ecnt + ONE;

      case (state)
        IDLE: begin
          if (rise) begin
            hcnt  <= ONE;
            pcnt  <= ONE;
            state <= HIGH;
          end
        end
        HIGH: begin
          pcnt <= sat_inc(pcnt);
          if (fall) state <= LOW;
          else      hcnt  <= sat_inc(hcnt);
        end
        LOW: begin
          if (rise) begin
            meas_valid <= 1'b1;
            high_time  <= hcnt;
            period     <= pcnt;
            duty       <= duty_of(hcnt);
            period_err <= (pcnt != NOM);
            stuck      <= 1'b0;
            hcnt       <= ONE;
            pcnt       <= ONE;
            state      <= HIGH;
          end else begin
            pcnt <= sat_inc(pcnt);
          end
        end
        default: state <= IDLE;
      endcase

      // Fires once per edge-free stretch: ecnt parks at TIMEOUT until the next edge.
      if (!edge_seen && ecnt == TO_LAST) begin
        meas_valid <= 1'b1;
        high_time  <= '0;
        period     <= '0;
        duty       <= lvl ? 8'hFF : 8'h00;
        period_err <= 1'b1;
        stuck      <= 1'b1;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (default build, glitch filter absent).
module tb_pwm_capture;

  localparam int CW      = 16;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic          meas_valid;
  logic [CW-1:0] high_time, period;
  logic [7:0]    duty;
  logic          period_err, stuck;

  pwm_capture #(.CW(CW), .NOM_PERIOD(256), .TIMEOUT(TIMEOUT), .DEGLITCH_LEN(4)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .meas_valid(meas_valid),
    .high_time(high_time), .period(period), .duty(duty),
    .period_err(period_err), .stuck(stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [CW-1:0] h;
    logic [CW-1:0] p;
    logic [7:0]    d;
    logic          e;
    logic          s;
    int            at;
  } pub_t;

  pub_t pubs[$];
  logic prev_mv = 1'b0;

  always @(negedge clk) begin
    if (meas_valid) begin
      check("meas_valid_one_cycle", {31'd0, prev_mv}, 32'd0);
      pubs.push_back('{high_time, period, duty, period_err, stuck, cyc});
    end
    prev_mv = meas_valid;
  end

  typedef struct {
    int h;
    int l;
    int exp_high;
    int exp_period;
    int exp_duty;
    bit exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pub(input string name, input int idx, input int h, input int p,
                           input int d, input bit e, input bit s);
    if (idx >= pubs.size()) begin
      check({name, "_present"}, 32'(pubs.size()), 32'(idx + 1));
    end else begin
      check({name, "_high_time"}, 32'(pubs[idx].h), 32'(h));
      check({name, "_period"},    32'(pubs[idx].p), 32'(p));
      check({name, "_duty"},      32'(pubs[idx].d), 32'(d));
      check({name, "_period_err"}, {31'd0, pubs[idx].e}, {31'd0, e});
      check({name, "_stuck"},     {31'd0, pubs[idx].s}, {31'd0, s});
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_meas_valid"}, {31'd0, meas_valid}, 32'd0);
    check({name, "_high_time"},  32'(high_time), 32'd0);
    check({name, "_period"},     32'(period), 32'd0);
    check({name, "_duty"},       32'(duty), 32'd0);
    check({name, "_period_err"}, {31'd0, period_err}, 32'd0);
    check({name, "_stuck"},      {31'd0, stuck}, 32'd0);
  endtask

  int t_edge;

  initial begin
    tbl[0] = '{101, 155, 101, 256, 100, 1'b0};
    tbl[1] = '{101, 155, 101, 256, 100, 1'b0};
    tbl[2] = '{  1, 255,   1, 256,   0, 1'b0};
    tbl[3] = '{255,   1, 255, 256, 254, 1'b0};
    tbl[4] = '{ 50, 100,  50, 150,  49, 1'b1};
    tbl[5] = '{101, 155, 101, 256, 100, 1'b0};
    tbl[6] = '{ 50,   2,  50,  52,  49, 1'b1};  // 2-clk low glitch inside a 101-clk high
    tbl[7] = '{ 49, 155,  49, 204,  48, 1'b1};
    tbl[8] = '{101, 155, 101, 256, 100, 1'b0};
    tbl[9] = '{200,  56, 200, 256, 199, 1'b0};

    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Back-to-back periods; each rise publishes the period before it.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].h);
      drive(1'b0, tbl[i].l);
    end
    pwm_in = 1'b1;
    t_edge = cyc;
    repeat (10) @(negedge clk);
    check("table_pub_count", 32'(pubs.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check_pub($sformatf("vec%0d", i), i, tbl[i].exp_high, tbl[i].exp_period,
                tbl[i].exp_duty, tbl[i].exp_err, 1'b0);
    pubs.delete();

    // Line held high: one stuck report TIMEOUT clk after the edge is seen.
    repeat (1990) @(negedge clk);
    check("stuck_hi_count", 32'(pubs.size()), 32'd1);
    check_pub("stuck_hi", 0, 0, 0, 8'hFF, 1'b1, 1'b1);
    if (pubs.size() > 0)
      check("stuck_hi_latency", 32'(pubs[0].at - t_edge), 32'(TIMEOUT + 3));
    pubs.delete();

    pwm_in = 1'b0;
    t_edge = cyc;
    repeat (2000) @(negedge clk);
    check("stuck_lo_count", 32'(pubs.size()), 32'd1);
    check_pub("stuck_lo", 0, 0, 0, 8'h00, 1'b1, 1'b1);
    if (pubs.size() > 0)
      check("stuck_lo_latency", 32'(pubs[0].at - t_edge), 32'(TIMEOUT + 3));
    check("stuck_lo_held", {31'd0, stuck}, 32'd1);
    pubs.delete();

    // Recovery: first rise out of IDLE is silent, the next one reports.
    drive(1'b1, 101);
    drive(1'b0, 155);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    check("recover_count", 32'(pubs.size()), 32'd1);
    check_pub("recover", 0, 101, 256, 100, 1'b0, 1'b0);
    check("recover_stuck_cleared", {31'd0, stuck}, 32'd0);
    pubs.delete();

    // Single-cycle reset in the middle of a high phase.
    drive(1'b1, 30);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    drive(1'b1, 60);
    drive(1'b0, 155);
    check("midrst_no_early_pub", 32'(pubs.size()), 32'd0);
    drive(1'b1, 101);
    drive(1'b0, 155);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_pub_count", 32'(pubs.size()), 32'd2);
    check_pub("midrst_full", 1, 101, 256, 100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
